// File: rtl/kronos_wb.sv
// Kronos RV32I write-back stage.
// Takes the execute payload over a valid/ready handshake and then does one of:
// commits ALU and link results, runs loads and stores on the data bus,
// redirects the PC on taken branches and jumps, or traps on illegal ops.
// Every register write is also returned to execute as a forwarding value.
// Optional feature: define KRONOS_MISALIGN_TRAP_EN to trap misaligned
// half/word accesses instead of silently aligning them.

package kronos_wb_pkg;
  typedef struct packed {
    logic [4:0]  rd;
    logic        rd_write;
    logic        branch;
    logic        branch_cond;
    logic [1:0]  ld_size;
    logic        ld_sign;
    logic        st;
    logic        illegal;
    logic [31:0] result1;
    logic [31:0] result2;
  } pipeEXWB_t;
endpackage

module kronos_wb
  import kronos_wb_pkg::*;
(
  input  logic        clk,
  input  logic        rstz,
  input  pipeEXWB_t   execute,
  input  logic        pipe_in_vld,
  output logic        pipe_in_rdy,
  output logic [31:0] regwr_data,
  output logic [4:0]  regwr_sel,
  output logic        regwr_en,
  output logic [31:0] fwd_data,
  output logic        fwd_vld,
  output logic [31:0] branch_target,
  output logic        branch,
  output logic        trap,
  output logic [31:0] data_addr,
  output logic [31:0] data_wr_data,
  output logic [3:0]  data_mask,
  output logic        data_wr_en,
  output logic        data_req,
  input  logic [31:0] data_rd_data,
  input  logic        data_ack
);

  typedef enum logic {STEADY = 1'b0, MEM = 1'b1} state_t;

  // Byte lane of the access; half and word accesses are forced onto their
  // natural lanes so that unaligned low address bits are ignored.
  function automatic logic [1:0] lane_off(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   lane_off = a;
      2'b01:   lane_off = {a[1], 1'b0};
      default: lane_off = 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   byte_mask = 4'b0001 << off;
      2'b01:   byte_mask = 4'b0011 << off;
      default: byte_mask = 4'hF;
    endcase
  endfunction

  // Store data is replicated into every lane so the bus only needs the mask.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   store_lanes = {4{d[7:0]}};
      2'b01:   store_lanes = {2{d[15:0]}};
      default: store_lanes = d;
    endcase
  endfunction

  // Pick the addressed lane out of the bus word and extend it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] d, input logic [1:0] off,
                                               input logic [1:0] size, input logic sign);
    logic [31:0] s;
    s = d >> {off, 3'b000};
    case (size)
      2'b00:   load_extract = sign ? {{24{s[7]}}, s[7:0]}   : {24'b0, s[7:0]};
      2'b01:   load_extract = sign ? {{16{s[15]}}, s[15:0]} : {16'b0, s[15:0]};
      default: load_extract = d;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [31:0] regwr_data_q, regwr_data_d;
  logic [4:0]  regwr_sel_q, regwr_sel_d;
  logic        regwr_en_q, regwr_en_d;
  logic [31:0] branch_target_q, branch_target_d;
  logic        branch_q, branch_d;
  logic        trap_q, trap_d;
  logic [31:0] data_addr_q, data_addr_d;
  logic [31:0] data_wr_data_q, data_wr_data_d;
  logic [3:0]  data_mask_q, data_mask_d;
  logic        data_wr_en_q, data_wr_en_d;
  logic        data_req_q, data_req_d;
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic [1:0]  ld_size_q, ld_size_d;
  logic        ld_sign_q, ld_sign_d;
  logic [1:0]  ld_off_q, ld_off_d;
  logic        ld_is_load_q, ld_is_load_d;

  logic        is_mem;
  logic        redirect;
  logic        misaligned;
  logic [1:0]  acc_off;

  assign is_mem   = (execute.ld_size != 2'b11) && (execute.st || execute.rd_write);
  assign redirect = !execute.branch_cond || execute.result1[0];
  assign acc_off  = lane_off(execute.ld_size, execute.result1[1:0]);

`ifdef KRONOS_MISALIGN_TRAP_EN
  assign misaligned = is_mem &&
                      (((execute.ld_size == 2'b01) && execute.result1[0]) ||
                       ((execute.ld_size == 2'b10) && (execute.result1[1:0] != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  // Next-state and registered-output decode for accept and bus completion.
  always_comb begin
    state_d         = state_q;
    regwr_en_d      = 1'b0;
    regwr_sel_d     = regwr_sel_q;
    regwr_data_d    = regwr_data_q;
    branch_d        = 1'b0;
    branch_target_d = branch_target_q;
    trap_d          = 1'b0;
    data_req_d      = data_req_q;
    data_addr_d     = data_addr_q;
    data_wr_data_d  = data_wr_data_q;
    data_mask_d     = data_mask_q;
    data_wr_en_d    = data_wr_en_q;
    ld_rd_d         = ld_rd_q;
    ld_size_d       = ld_size_q;
    ld_sign_d       = ld_sign_q;
    ld_off_d        = ld_off_q;
    ld_is_load_d    = ld_is_load_q;

    case (state_q)
      STEADY: begin
        if (pipe_in_vld) begin
          if (execute.illegal || misaligned) begin
            trap_d = 1'b1;
          end else if (execute.branch) begin
            if (redirect) begin
              branch_d        = 1'b1;
              branch_target_d = execute.result2;
            end
            if (execute.rd_write) begin
              regwr_en_d   = 1'b1;
              regwr_sel_d  = execute.rd;
              regwr_data_d = execute.result1;
            end
          end else if (is_mem) begin
            state_d        = MEM;
            data_req_d     = 1'b1;
            data_addr_d    = {execute.result1[31:2], 2'b00};
            data_mask_d    = byte_mask(execute.ld_size, acc_off);
            data_wr_data_d = store_lanes(execute.ld_size, execute.result2);
            data_wr_en_d   = execute.st;
            ld_rd_d        = execute.rd;
            ld_size_d      = execute.ld_size;
            ld_sign_d      = execute.ld_sign;
            ld_off_d       = acc_off;
            ld_is_load_d   = !execute.st;
          end else if (execute.rd_write && (execute.rd != 5'd0)) begin
            regwr_en_d   = 1'b1;
            regwr_sel_d  = execute.rd;
            regwr_data_d = execute.result1;
          end
        end
      end
      MEM: begin
        if (data_ack) begin
          state_d    = STEADY;
          data_req_d = 1'b0;
          if (ld_is_load_q && (ld_rd_q != 5'd0)) begin
            regwr_en_d   = 1'b1;
            regwr_sel_d  = ld_rd_q;
            regwr_data_d = load_extract(data_rd_data, ld_off_q, ld_size_q, ld_sign_q);
          end
        end
      end
      default: state_d = STEADY;
    endcase
  end

  // State and output registers; reset also abandons any bus access in flight.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q         <= STEADY;
      regwr_data_q    <= '0;
      regwr_sel_q     <= '0;
      regwr_en_q      <= 1'b0;
      branch_target_q <= '0;
      branch_q        <= 1'b0;
      trap_q          <= 1'b0;
      data_addr_q     <= '0;
      data_wr_data_q  <= '0;
      data_mask_q     <= '0;
      data_wr_en_q    <= 1'b0;
      data_req_q      <= 1'b0;
      ld_rd_q         <= '0;
      ld_size_q       <= '0;
      ld_sign_q       <= 1'b0;
      ld_off_q        <= '0;
      ld_is_load_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      regwr_data_q    <= regwr_data_d;
      regwr_sel_q     <= regwr_sel_d;
      regwr_en_q      <= regwr_en_d;
      branch_target_q <= branch_target_d;
      branch_q        <= branch_d;
      trap_q          <= trap_d;
      data_addr_q     <= data_addr_d;
      data_wr_data_q  <= data_wr_data_d;
      data_mask_q     <= data_mask_d;
      data_wr_en_q    <= data_wr_en_d;
      data_req_q      <= data_req_d;
      ld_rd_q         <= ld_rd_d;
      ld_size_q       <= ld_size_d;
      ld_sign_q       <= ld_sign_d;
      ld_off_q        <= ld_off_d;
      ld_is_load_q    <= ld_is_load_d;
    end
  end

  assign pipe_in_rdy   = (state_q == STEADY);
  assign regwr_data    = regwr_data_q;
  assign regwr_sel     = regwr_sel_q;
  assign regwr_en      = regwr_en_q;
  assign fwd_data      = regwr_data_q;
  assign fwd_vld       = regwr_en_q;
  assign branch_target = branch_target_q;
  assign branch        = branch_q;
  assign trap          = trap_q;
  assign data_addr     = data_addr_q;
  assign data_wr_data  = data_wr_data_q;
  assign data_mask     = data_mask_q;
  assign data_wr_en    = data_wr_en_q;
  assign data_req      = data_req_q;

endmodule

// File: doc/kronos_wb.md
# kronos_WB

Kronos RV32I write-back stage: final pipestage after execute. It consumes `pipeEXWB_t` via a valid/ready handshake and then does one of the following:
- commits ALU results to the register file;
- performs loads and stores on the data bus;
- resolves branches and jumps;
- flags illegal instructions.

Every register commit is also driven back to execute as the forwarding value that clears register hazards.

## Interface
Parameters: none.

- `clk`  in  1  clock
- `rstz`  in  1  reset, asynchronous, active-low
- `execute`  in  `pipeEXWB_t`  fields: `rd`, `rd_write`, `branch`, `branch_cond`, `ld_size`[1:0], `ld_sign`, `st`, `illegal`, `result1`[31:0], `result2`[31:0]
- `pipe_in_vld`  in  1  execute payload valid
- `pipe_in_rdy`  out  1  WB can accept
- `regwr_data`  out  32  register write data
- `regwr_sel`  out  5  register write index
- `regwr_en`  out  1  register write strobe (1 cycle)
- `fwd_data`  out  32  forwarded register value to execute
- `fwd_vld`  out  1  forward valid (1 cycle)
- `branch_target`  out  32  next PC on redirect
- `branch`  out  1  PC redirect pulse
- `trap`  out  1  illegal or misaligned pulse
- `data_addr`  out  32  word-aligned address ({`result1`[31:2],2'b00})
- `data_wr_data`  out  32  store data, lane-replicated
- `data_mask`  out  4  byte enables
- `data_wr_en`  out  1  1 = store, 0 = load
- `data_req`  out  1  bus request, held until ack
- `data_rd_data`  in  32  load data
- `data_ack`  in  1  bus completion, 1 cycle

## Operation
Payload semantics:
- `result1`: ALU result, memory address, or branch condition (bit 0).
- `result2`: store data or branch target.
- A load is `rd_write` && `ld_size`!=2'b11 && !`st`. Encoding: `ld_size` 00 byte, 01 half, 10 word; 11 means no memory access.

States:
- `STEADY`: `pipe_in_rdy`=1; accepts on `pipe_in_vld`.
- `MEM`: `pipe_in_rdy`=0; `data_req`=1 until `data_ack`.

Handling of an accepted instruction, all outputs registered:
- **`illegal`**: `trap` pulse. No write, branch or bus access. Stay in `STEADY`.
- **Branch** (`branch`=1): a redirect occurs if `branch_cond`=0, or if `branch_cond`=1 and `result1`[0]=1.
  - On redirect: `branch`=1 and `branch_target`=`result2`.
  - If `rd_write`, write `result1` (link) to `rd`.
- **ALU op**: if `rd_write` && `rd`!=0, write `result1`.
- **Load or store**: go to `MEM`.
  - `data_mask` for byte: 1<<a[1:0]; for half: 4'b0011<<a[1:0]; for word: 4'hF.
  - Store data is replicated per lane: byte {4{d[7:0]}}, half {2{d[15:0]}}.
- **On `data_ack`**:
  - Load: select the lane by a[1:0], sign-extend if `ld_sign`, else zero-extend. Write `rd` unless `rd`=0.
  - Return to `STEADY`.
- **Every register write**: `regwr_en`=`fwd_vld`=1 and `fwd_data`=`regwr_data`, in the same cycle.

## Timing
- Reset values: `pipe_in_rdy`=1 (state `STEADY`). All other outputs are 0: strobes, `data_req`, `data_wr_en`, `data_mask`, `data_addr`, `data_wr_data`, `regwr_*`, `fwd_*`, `branch`, `branch_target`, `trap`.
- Accept edge N:
  - ALU, branch or illegal: outputs pulse in cycle N+1. Back-to-back accepts are allowed every cycle.
  - Memory op: `data_req`=1 from N+1. Ack sampled at edge M. Load write-back and `fwd_vld` occur in cycle M+1; `pipe_in_rdy` rises in cycle M+1.
  - Minimum memory occupancy: 2 cycles (ack in N+1).
- `data_req` and the address, data and mask are stable while waiting. `data_ack` while idle is ignored.
- Reset asserted mid-`MEM`: `data_req` drops asynchronously and the access is abandoned; no write-back.
- `pipe_in_vld` while `pipe_in_rdy`=0 is held by execute; WB does not sample it.

## Configuration
- `KRONOS_MISALIGN_TRAP_EN` defined: a half access with a[0]=1 or a word access with a[1:0]!=0 is a misaligned access. It raises `trap` in cycle N+1 with no bus request, write or forward, and stays in `STEADY`.
- Undefined: no check is made.
  - Word: a[1:0] ignored.
  - Half: lane chosen by a[1] only (mask 0011 or 1100).

## Test plan
- ALU write: `rd`=5, `result1`=0x1234_5678, `rd_write`=1 -> cycle N+1 `regwr_en`=1, `regwr_sel`=5, `fwd_vld`=1, `fwd_data`=0x1234_5678. Repeat with `rd`=0 -> no strobes.
- Signed byte load: addr 0x103, `ld_size`=00, `ld_sign`=1, memory 0x80xx_xxxx, ack after 3 cycles -> `data_addr`=0x100, `data_mask`=4'b1000, `data_req` held 3 cycles, write 0xFFFF_FF80 one cycle after ack. Repeat with `ld_sign`=0 -> 0x0000_0080.
- Half store: addr 0x202, data 0xAAAA_BEEF -> `data_wr_en`=1, `data_mask`=4'b1100, `data_wr_data`=0xBEEF_BEEF, no `regwr_en`, `pipe_in_rdy` low until the cycle after ack.
- Conditional branch: `branch_cond`=1, `result1`=1, `result2`=0x400 -> `branch`=1, `branch_target`=0x400. With `result1`=0 -> no `branch`. JAL with `rd`=1, `result1`=0x104 -> redirect plus write of 0x104.
- Illegal, and misaligned word at 0x202 with `KRONOS_MISALIGN_TRAP_EN` -> `trap` pulse, no `data_req`, no `regwr_en`.
- Reset asserted while `data_req`=1 -> `data_req`=0 immediately. After release, `pipe_in_rdy`=1 and a late ack is ignored.
